mult_sequencer: RTL and testbench

Multi-cycle 32x32 -> 64-bit integer multiplier for the MIPS single-cycle/multi-cycle datapath (MULT/MULTU, HI/LO). Runs radix-2 shift-add with one 32-bit ALU pass per cycle, reusing the team's `thirty_two_bit_alu` as its only adder. Signed operands are handled by magnitude conversion before iteration and conditional two's-complement negation after. A start/busy/done handshake lets the main control unit stall until the result is ready.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/thirty_two_bit_alu.sv | 39 +++
 rtl/mult_sequencer.sv | 119 +++++++++++
 tb/tb_mult_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier and its ALU.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_NEG_LO,
    S_NEG_HI,
    S_DONE
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int ITER_COUNT = 32;
  localparam logic [4:0] CNT_LAST = 5'(ITER_COUNT - 1);

endpackage

// File: rtl/thirty_two_bit_alu.sv
// 32-bit MIPS ALU: AND/OR/ADD/SUB/SLT, explicit carry-in, carry-out and overflow.
// Combinational; op[2] selects b inversion so SUB is a + ~b + cin.
module thirty_two_bit_alu
  import mult_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        cin,
  input  logic        less,
  output logic [31:0] result,
  output logic        cout,
  output logic        overflow
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        set;

  assign b_eff    = op[2] ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {32'b0, cin};
  assign cout     = sum[32];
  assign overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
  // Chained-slice SLT: bit 0 takes the MSB set, upper bits take the less input
  assign set      = sum[31] ^ overflow;

  always_comb begin
    result = 32'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum[31:0];
      ALU_SUB: result = sum[31:0];
      ALU_SLT: result = {{31{less}}, set};
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential 32x32->64 MULT/MULTU using one ALU pass per cycle; 33 cycles unsigned, 37 signed.
// start is only honoured in IDLE; busy stalls the caller until the done pulse.
module mult_sequencer
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state, state_nxt;
  logic [31:0] mcand, hi_q, lo_q;
  logic [4:0]  cnt;
  logic        neg, sgn, carry, busy_q;

  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_cout, alu_v_unused;

  thirty_two_bit_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .cin      (alu_cin),
    .less     (1'b0),
    .result   (alu_r),
    .cout     (alu_cout),
    .overflow (alu_v_unused)
  );

  always_comb begin
    state_nxt = state;
    alu_a     = 32'b0;
    alu_b     = 32'b0;
    alu_op    = ALU_ADD;
    alu_cin   = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = is_signed ? S_ABS_A : S_ITER;
      S_ABS_A: begin
        alu_op = ALU_SUB; alu_b = mcand; alu_cin = 1'b1;
        state_nxt = S_ABS_B;
      end
      S_ABS_B: begin
        alu_op = ALU_SUB; alu_b = lo_q; alu_cin = 1'b1;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        alu_op = ALU_ADD; alu_a = hi_q; alu_b = mcand;
        if (cnt == CNT_LAST) state_nxt = sgn ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        alu_op = ALU_SUB; alu_b = lo_q; alu_cin = 1'b1;
        state_nxt = S_NEG_HI;
      end
      // Borrow from the low-word negation ripples into the high word
      S_NEG_HI: begin
        alu_op = ALU_SUB; alu_b = hi_q; alu_cin = carry;
        state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      mcand  <= 32'b0;
      hi_q   <= 32'b0;
      lo_q   <= 32'b0;
      cnt    <= 5'd0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      carry  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            lo_q  <= b;
            hi_q  <= 32'b0;
            neg   <= is_signed & (a[31] ^ b[31]);
            sgn   <= is_signed;
            cnt   <= 5'd0;
          end
        end
        S_ABS_A: if (mcand[31]) mcand <= alu_r;
        S_ABS_B: if (lo_q[31]) lo_q <= alu_r;
        S_ITER: begin
          cnt <= cnt + 5'd1;
          if (lo_q[0]) {hi_q, lo_q} <= {alu_cout, alu_r, lo_q[31:1]};
          else         {hi_q, lo_q} <= {1'b0, hi_q, lo_q[31:1]};
        end
        S_NEG_LO: begin
          carry <= alu_cout;
          if (neg) lo_q <= alu_r;
        end
        S_NEG_HI: if (neg) hi_q <= alu_r;
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = (state == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: fixed vectors, random operands against an arithmetic model, handshake corners.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'b0, b = 32'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mult_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'({32'b0, x} * {32'b0, y});
    return p;
  endfunction

  // Call at a negedge after accept edge; returns at the negedge of the done cycle.
  task automatic wait_done(output int lat, output logic [31:0] rh, output logic [31:0] rl);
    lat = 0; rh = 32'b0; rl = 32'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; rh = hi; rl = lo;
        break;
      end
    end
  endtask

  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] rh, output logic [31:0] rl);
    @(negedge clk);
    start = 1'b1; is_signed = s; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, rh, rl);
  endtask

  vec_t tbl[8];

  initial begin
    int lat, busy_err, done_cnt, done_cyc;
    logic [31:0] rh, rl;
    logic s;
    logic [31:0] x, y;

    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33};
    tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 37};
    tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 37};
    tbl[3] = '{1'b1, 32'hFFFFFFFB, 32'h00000000, 64'h00000000_00000000, 37};
    tbl[4] = '{1'b0, 32'h00000006, 32'h00000007, 64'h00000000_0000002A, 33};
    tbl[5] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 37};
    tbl[6] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, 37};
    tbl[7] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 37};

    #12;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].s, tbl[i].x, tbl[i].y, lat, rh, rl);
      chk($sformatf("vec%0d_prod", i), {rh, rl}, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: x = 32'h0;
        1: x = 32'h80000000;
        2: x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      do_op(s, x, y, lat, rh, rl);
      chk($sformatf("rnd%0d_prod s=%0d a=%h b=%h", i, s, x, y), {rh, rl}, ref_prod(s, x, y));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), s ? 64'd37 : 64'd33);
    end

    // start pulses while busy and in the DONE cycle must be ignored
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    busy_err = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (busy !== (c <= 33)) busy_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = c; rh = hi; rl = lo; end
      end
      if (c == 5 || c == 33) begin start = 1'b1; a = 32'd100; b = 32'd100; end
      else start = 1'b0;
    end
    chk("ign_busy_profile_errs", 64'(busy_err), 64'd0);
    chk("ign_done_count", 64'(done_cnt), 64'd1);
    chk("ign_done_cycle", 64'(done_cyc), 64'd33);
    chk("ign_prod", {rh, rl}, 64'd42);
    chk("ign_hold_after", {hi, lo}, 64'd42);

    // async reset in the middle of a signed op
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; a = 32'hFFFFFFFD; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    @(negedge clk);
    if (done) done_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done_after", 64'(done_cnt), 64'd0);
    do_op(1'b0, 32'd2, 32'd3, lat, rh, rl);
    chk("rst_recover_prod", {rh, rl}, 64'd6);
    chk("rst_recover_lat", 64'(lat), 64'd33);

    // back-to-back: start in the IDLE cycle immediately after DONE
    do_op(1'b0, 32'd5, 32'd5, lat, rh, rl);
    chk("b2b_first", {rh, rl}, 64'd25);
    @(negedge clk);
    chk("b2b_idle_busy", {63'b0, busy}, 64'd0);
    chk("b2b_hold", {hi, lo}, 64'd25);
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_accept_lo", {hi, lo}, 64'd4);
    wait_done(lat, rh, rl);
    chk("b2b_second", {rh, rl}, 64'd12);
    chk("b2b_lat", 64'(lat), 64'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
